module_booth_sequencer: RTL and testbench

Sequences one Booth multiplication from decoded keypad events. It builds signed decimal operands A and B from digit keys. It then issues a one-cycle start to the Booth multiplier datapath and waits for done, with a timeout. Finally it holds the product, or an error code, for the 7-segment display driver. It sits in module_top between the keypad decoder and the multiplier/display blocks.

---
 rtl/booth_ctrl_pkg.sv | 27 ++
 rtl/module_operand_entry.sv | 62 ++++++
 rtl/module_booth_sequencer.sv | 166 ++++++++++++++++
 tb/tb_module_booth_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_ctrl_pkg.sv
// Shared types and constants for the Booth multiplication sequencer.
package booth_ctrl_pkg;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_START,
        S_WAIT,
        S_SHOW
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_ENTER     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_SIGN      = 4'hC;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;
    localparam logic [1:0] DISP_ERR = 2'd3;

    // Decimal digit keys occupy codes 0x0..0x9.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/module_operand_entry.sv
// Signed decimal operand accumulator: magnitude, digit count and sign.
// A clear in the same cycle as a digit or sign toggle is applied first,
// so "clear + digit" restarts the operand with that digit.
module module_operand_entry
    import booth_ctrl_pkg::*;
#(
    parameter int OP_W       = 8,
    parameter int MAX_DIGITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            digit_we,
    input  logic [3:0]      digit,
    input  logic            sign_tgl,
    output logic [OP_W-1:0] value
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [OP_W-1:0]  mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;

    // Next accumulator state: optional clear, then digit append, then sign flip.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        mag_d  = mag_q;
        cnt_d  = cnt_q;
        sign_d = sign_q;
        if (clr) begin
            mag_d  = '0;
            cnt_d  = '0;
            sign_d = 1'b0;
        end
        if (digit_we && (cnt_d < CNT_W'(MAX_DIGITS))) begin
            mag_d = mag_d * OP_W'(10) + OP_W'(digit);
            cnt_d = cnt_d + 1'b1;
        end
        if (sign_tgl) begin
            sign_d = ~sign_d;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            mag_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            cnt_q  <= cnt_d;
            sign_q <= sign_d;
        end
    end

    // Negating a zero magnitude yields zero, so "-0" reads as 0.
    assign value = sign_q ? (-mag_q) : mag_q;

endmodule

// File: rtl/module_booth_sequencer.sv
// Keypad-driven sequencer for one Booth multiplication: operand entry,
// start/done handshake with timeout, and result/error hold for display.
module module_booth_sequencer
    import booth_ctrl_pkg::*;
#(
    parameter int OP_W        = 8,
    parameter int MAX_DIGITS  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              mult_start,
    output logic [OP_W-1:0]   mult_a,
    output logic [OP_W-1:0]   mult_b,
    input  logic              mult_done,
    input  logic [2*OP_W-1:0] mult_result,
    output logic [2*OP_W-1:0] disp_value,
    output logic [1:0]        disp_sel,
    output logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     mult_a_q, mult_a_d;
    logic [OP_W-1:0]     mult_b_q, mult_b_d;
    logic                mult_start_q, mult_start_d;
    logic                busy_q, busy_d;
    logic [1:0]          disp_sel_q, disp_sel_d;
    logic [2*OP_W-1:0]   res_q, res_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                ent_clr, ent_we, ent_tgl;
    logic [OP_W-1:0]     op_value;
    logic                key_digit, key_enter, key_clear, key_sign;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_enter = key_valid && (key_code == KEY_ENTER);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign key_sign  = key_valid && (key_code == KEY_SIGN);

    module_operand_entry #(
        .OP_W       (OP_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .clr      (ent_clr),
        .digit_we (ent_we),
        .digit    (key_code),
        .sign_tgl (ent_tgl),
        .value    (op_value)
    );

    // FSM next-state, operand latching, timeout and display decisions.
    always_comb begin
        state_d    = state_q;
        mult_a_d   = mult_a_q;
        mult_b_d   = mult_b_q;
        disp_sel_d = disp_sel_q;
        res_d      = res_q;
        tmo_d      = tmo_q;
        ent_clr    = 1'b0;
        ent_we     = 1'b0;
        ent_tgl    = 1'b0;

        if (key_clear) begin
            // Abort from any state; a later mult_done is ignored outside S_WAIT.
            state_d    = S_ENTER_A;
            ent_clr    = 1'b1;
            mult_a_d   = '0;
            mult_b_d   = '0;
            res_d      = '0;
            disp_sel_d = DISP_A;
            tmo_d      = '0;
        end else begin
            unique case (state_q)
                S_ENTER_A: begin
                    ent_we  = key_digit;
                    ent_tgl = key_sign;
                    if (key_enter) begin
                        mult_a_d   = op_value;
                        ent_clr    = 1'b1;
                        state_d    = S_ENTER_B;
                        disp_sel_d = DISP_B;
                    end
                end
                S_ENTER_B: begin
                    ent_we  = key_digit;
                    ent_tgl = key_sign;
                    if (key_enter) begin
                        mult_b_d = op_value;
                        state_d  = S_START;
                    end
                end
                S_START: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over an expiring timeout in the same cycle.
                    if (mult_done) begin
                        res_d      = mult_result;
                        disp_sel_d = DISP_RES;
                        state_d    = S_SHOW;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        res_d      = '0;
                        disp_sel_d = DISP_ERR;
                        state_d    = S_SHOW;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    // A digit or sign key starts a fresh operand A.
                    if (key_digit || key_sign) begin
                        ent_clr    = 1'b1;
                        ent_we     = key_digit;
                        ent_tgl    = key_sign;
                        disp_sel_d = DISP_A;
                        state_d    = S_ENTER_A;
                    end
                end
                default: state_d = S_ENTER_A;
            endcase
        end

        mult_start_d = (state_d == S_START);
        busy_d       = (state_d == S_START) || (state_d == S_WAIT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ENTER_A;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
            busy_q       <= 1'b0;
            disp_sel_q   <= DISP_A;
            res_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
            busy_q       <= busy_d;
            disp_sel_q   <= disp_sel_d;
            res_q        <= res_d;
            tmo_q        <= tmo_d;
        end
    end

    assign mult_start = mult_start_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign disp_sel   = disp_sel_q;
    assign busy       = busy_q;
    // Outside S_SHOW the display follows the live operand, sign-extended.
    assign disp_value = (state_q == S_SHOW) ? res_q
                                            : {{OP_W{op_value[OP_W-1]}}, op_value};

endmodule

// File: tb/tb_module_booth_sequencer.sv
// Directed testbench for module_booth_sequencer with a behavioural multiplier
// and a product scoreboard.
module tb_module_booth_sequencer;

    localparam int OP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_valid;
    logic [3:0]        key_code;
    logic              mult_start;
    logic [OP_W-1:0]   mult_a;
    logic [OP_W-1:0]   mult_b;
    logic              mult_done;
    logic [2*OP_W-1:0] mult_result;
    logic [2*OP_W-1:0] disp_value;
    logic [1:0]        disp_sel;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*OP_W-1:0] exp_q[$];

    module_booth_sequencer #(
        .OP_W        (OP_W),
        .MAX_DIGITS  (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .mult_start  (mult_start),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_done   (mult_done),
        .mult_result (mult_result),
        .disp_value  (disp_value),
        .disp_sel    (disp_sel),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the key was sampled.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Called in the cycle mult_start should be high; models the multiplier.
    task automatic run_mult(input string tag, input int a, input int b,
                            input int delay, input bit junk);
        logic [2*OP_W-1:0] prod;
        logic [2*OP_W-1:0] got;
        logic [OP_W-1:0]   ea;
        logic [OP_W-1:0]   eb;
        ea   = OP_W'(a);
        eb   = OP_W'(b);
        prod = (2*OP_W)'(a * b);
        check({tag, "_start_hi"}, mult_start, 1);
        check({tag, "_mult_a"}, mult_a, ea);
        check({tag, "_mult_b"}, mult_b, eb);
        exp_q.push_back(prod);
        @(negedge clk);
        check({tag, "_start_lo"}, mult_start, 0);
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < delay; i++) begin
            key_valid = junk && (i == 1);
            key_code  = 4'h7;
            @(negedge clk);
        end
        key_valid   = 1'b0;
        check({tag, "_busy_wait"}, busy, 1);
        mult_done   = 1'b1;
        mult_result = prod;
        @(negedge clk);
        mult_done   = 1'b0;
        mult_result = '0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_disp_value"}, disp_value, got);
        end
        check({tag, "_disp_sel"}, disp_sel, 2);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        mult_done   = 1'b0;
        mult_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_disp_value", disp_value, 0);
        check("rst_disp_sel", disp_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_mult_start", mult_start, 0);
        check("rst_mult_a", mult_a, 0);

        // Asynchronous reset mid-entry
        press(4'h4);
        press(4'h2);
        check("entry_42", disp_value, 16'h002A);
        #2 rst = 1'b1;
        #1;
        check("async_rst_disp_value", disp_value, 0);
        check("async_rst_disp_sel", disp_sel, 0);
        check("async_rst_mult_start", mult_start, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 12 * -7
        press(4'h1);
        press(4'h2);
        check("entry_12", disp_value, 16'h000C);
        press(4'hA);
        check("enterA_disp_sel", disp_sel, 1);
        check("enterA_mult_a", mult_a, 8'd12);
        check("enterA_disp_cleared", disp_value, 0);
        press(4'hC);
        press(4'h7);
        check("entry_neg7", disp_value, 16'hFFF9);
        press(4'hA);
        run_mult("mul_12x-7", 12, -7, 8, 1'b0);
        check("res_-84", disp_value, 16'hFFAC);

        // Enter in S_SHOW is ignored; a digit starts new operand A
        press(4'hA);
        check("show_enter_sel", disp_sel, 2);
        check("show_enter_val", disp_value, 16'hFFAC);
        press(4'h5);
        check("show_digit_sel", disp_sel, 0);
        check("show_digit_val", disp_value, 16'h0005);

        // 99 * -99 with the third digit ignored and junk keys during S_WAIT
        press(4'hB);
        check("clear_val", disp_value, 0);
        press(4'h9);
        press(4'h9);
        press(4'h9);
        check("entry_999", disp_value, 16'h0063);
        press(4'hA);
        check("enter_99", mult_a, 8'd99);
        press(4'hC);
        press(4'h9);
        press(4'h9);
        check("entry_neg99", disp_value, 16'hFF9D);
        press(4'hA);
        run_mult("mul_99x-99", 99, -99, 3, 1'b1);
        check("res_-9801", disp_value, 16'hD9B7);

        // Timeout: no done for 64 cycles in S_WAIT
        press(4'hB);
        press(4'hC);
        check("neg_zero", disp_value, 0);
        press(4'h3);
        check("entry_neg3", disp_value, 16'hFFFD);
        press(4'hA);
        press(4'h4);
        press(4'hA);
        check("tmo_start", mult_start, 1);
        check("tmo_mult_a", mult_a, 8'hFD);
        check("tmo_mult_b", mult_b, 8'd4);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                cyc = i;
                break;
            end
        end
        check("tmo_cycles", cyc, 65);
        check("tmo_disp_sel", disp_sel, 3);
        check("tmo_disp_value", disp_value, 0);
        mult_done   = 1'b1;
        mult_result = 16'h1234;
        @(negedge clk);
        mult_done   = 1'b0;
        mult_result = '0;
        @(negedge clk);
        check("late_done_sel", disp_sel, 3);
        check("late_done_val", disp_value, 0);
        check("late_done_busy", busy, 0);

        // Clear during S_WAIT, then a stray done
        press(4'hB);
        press(4'h6);
        press(4'hA);
        press(4'h5);
        press(4'hA);
        check("abort_start", mult_start, 1);
        @(negedge clk);
        press(4'h7);
        press(4'hA);
        check("wait_keys_busy", busy, 1);
        check("wait_keys_sel", disp_sel, 1);
        press(4'hB);
        mult_done   = 1'b1;
        mult_result = 16'h0BAD;
        @(negedge clk);
        mult_done   = 1'b0;
        mult_result = '0;
        check("abort_disp_sel", disp_sel, 0);
        check("abort_disp_value", disp_value, 0);
        check("abort_busy", busy, 0);
        check("abort_mult_a", mult_a, 0);
        check("abort_mult_b", mult_b, 0);
        press(4'h2);
        check("after_abort_digit", disp_value, 16'h0002);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
